gate_truth_checker: RTL and testbench

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 161 ++++++++++++++++
 tb/tb_gate_truth_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
`default_nettype none
//==============================================================================
// Module   : gate_truth_checker
// Brief    : Sweeps every input vector into a combinational DUT, waits SETTLE
//            cycles per vector, and compares its output against a truth table.
//            Optional observed-table capture: define GATE_CHECK_OBS_TABLE_EN.
// Revision : 1.0 - initial release
//==============================================================================
module gate_truth_checker #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      drive,
    input  logic                 sample,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      fail_vec,
    output logic                 fail_valid,
    output logic [2**N_IN-1:0]   obs_table
);

    localparam logic [3:0]      c_settle = 4'(SETTLE);
    localparam logic [N_IN-1:0] c_last   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state;
    logic [N_IN-1:0]   r_vec, w_vec;
    logic [3:0]        r_cnt, w_cnt;
    logic [N_IN:0]     r_err, w_err;
    logic [N_IN-1:0]   r_fail_vec, w_fail_vec;
    logic              r_fail_valid, w_fail_valid;
    logic              r_pass, w_pass;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              w_launch;
    logic              w_compare;
    logic              w_mismatch;

    assign w_launch   = (r_state == ST_IDLE) && start;
    assign w_compare  = (r_state == ST_RUN) && (r_cnt == 4'd0);
    assign w_mismatch = sample != EXPECT[r_vec];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_vec        <= w_vec;
            r_cnt        <= w_cnt;
            r_err        <= w_err;
            r_fail_vec   <= w_fail_vec;
            r_fail_valid <= w_fail_valid;
            r_pass       <= w_pass;
            r_busy       <= w_busy;
            r_done       <= w_done;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_vec        = r_vec;
        w_cnt        = r_cnt;
        w_err        = r_err;
        w_fail_vec   = r_fail_vec;
        w_fail_valid = r_fail_valid;
        w_pass       = r_pass;
        w_busy       = r_busy;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_state      = ST_RUN;
                    w_vec        = '0;
                    w_cnt        = c_settle;
                    w_err        = '0;
                    w_fail_vec   = '0;
                    w_fail_valid = 1'b0;
                    w_pass       = 1'b0;
                    w_busy       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_compare) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    if (w_mismatch) begin
                        w_err = r_err + (N_IN+1)'(1);
                        if (!r_fail_valid) begin
                            w_fail_vec   = r_vec;
                            w_fail_valid = 1'b1;
                        end
                    end
                    if (r_vec != c_last) begin
                        w_vec = r_vec + N_IN'(1);
                        w_cnt = c_settle;
                    end else begin
                        // Vector returns to 0 so drive is idle while DONE.
                        w_state = ST_DONE;
                        w_vec   = '0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_err == '0);
                    end
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

`ifdef GATE_CHECK_OBS_TABLE_EN
    logic [2**N_IN-1:0] r_obs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_obs <= '0;
        end else if (w_launch) begin
            r_obs <= '0;
        end else if (w_compare) begin
            r_obs[r_vec] <= sample;
        end
    end

    assign obs_table = r_obs;
`else
    assign obs_table = '0;
`endif

    assign drive      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
//==============================================================================
// Module   : tb_gate_truth_checker
// Brief    : Scoreboard bench for gate_truth_checker (SETTLE=1 and SETTLE=0).
// Revision : 1.0 - initial release
//==============================================================================
module tb_gate_truth_checker;

    localparam logic [3:0] TB_EXPECT = 4'b1000;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [1:0] fv;
        logic       fvalid;
        logic [3:0] obs;
        logic [7:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic [1:0] drive_a, drive_b, fail_vec_a, fail_vec_b;
    logic sample_a, sample_b, busy_a, busy_b, done_a, done_b;
    logic pass_a, pass_b, fail_valid_a, fail_valid_b;
    logic [2:0] err_count_a, err_count_b;
    logic [3:0] obs_table_a, obs_table_b;
    int   mode_a = 0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    int   done_at;
    bit   busy_lo;
    logic [1:0] trace [40];

    always #5 clk = ~clk;

    // Mode 0 = AND gate, 1 = OR gate, 2 = output stuck at 0
    function automatic logic model(input int m, input logic [1:0] v);
        case (m)
            0:       return v[0] & v[1];
            1:       return v[0] | v[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t expect_for(input int m, input int settle);
        exp_t r;
        logic [3:0] obs;
        logic o;
        r   = '0;
        obs = '0;
        for (int i = 0; i < 4; i++) begin
            o = model(m, 2'(i));
            obs[i] = o;
            if (o != TB_EXPECT[i]) begin
                r.err = r.err + 3'd1;
                if (!r.fvalid) begin
                    r.fv     = 2'(i);
                    r.fvalid = 1'b1;
                end
            end
        end
        r.pass = (r.err == 3'd0);
        r.cyc  = 8'(4 * (settle + 1));
`ifdef GATE_CHECK_OBS_TABLE_EN
        r.obs  = obs;
`else
        r.obs  = 4'b0000;
`endif
        return r;
    endfunction

    assign sample_a = model(mode_a, drive_a);
    assign sample_b = model(0, drive_b);

    gate_truth_checker #(.N_IN(2), .SETTLE(1), .EXPECT(TB_EXPECT)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .drive(drive_a), .sample(sample_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
        .fail_vec(fail_vec_a), .fail_valid(fail_valid_a), .obs_table(obs_table_a)
    );

    gate_truth_checker #(.N_IN(2), .SETTLE(0), .EXPECT(TB_EXPECT)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .drive(drive_b), .sample(sample_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
        .fail_vec(fail_vec_b), .fail_valid(fail_valid_b), .obs_table(obs_table_b)
    );

    // Drives one sweep on instance A; returns at the negedge where done is seen.
    task automatic run_a(input int m, input bit hold);
        sb.push_back(expect_for(m, 1));
        mode_a = m;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = hold;
        done_at = -1;
        busy_lo = 1'b0;
        for (int k = 0; k < 40; k++) begin
            trace[k] = drive_a;
            if (done_a) begin
                done_at = k;
                break;
            end
            if (!busy_a) busy_lo = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (drive_a !== 2'b00 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_ctl got drive=%b busy=%b done=%b want 00 0 0", drive_a, busy_a, done_a); end
        checks++; if (pass_a !== 1'b0 || err_count_a !== 3'd0 || fail_vec_a !== 2'd0 || fail_valid_a !== 1'b0) begin errors++; $display("FAIL reset_res got pass=%b err=%0d fv=%0d fvalid=%b want all 0", pass_a, err_count_a, fail_vec_a, fail_valid_a); end
        checks++; if (obs_table_a !== 4'b0000 || obs_table_b !== 4'b0000 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_obs got obs_a=%b obs_b=%b busy_b=%b want 0000 0000 0", obs_table_a, obs_table_b, busy_b); end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_and_sweep();
        run_a(0, 1'b0);
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc)) begin errors++; $display("FAIL and_done_cycle got %0d want %0d", done_at, e.cyc); end
        checks++; if (pass_a !== e.pass || err_count_a !== e.err || fail_valid_a !== e.fvalid) begin errors++; $display("FAIL and_result got pass=%b err=%0d fvalid=%b want %b %0d %b", pass_a, err_count_a, fail_valid_a, e.pass, e.err, e.fvalid); end
        checks++; if (obs_table_a !== e.obs) begin errors++; $display("FAIL and_obs got %b want %b", obs_table_a, e.obs); end
        checks++; if (busy_lo) begin errors++; $display("FAIL and_busy got low-during-run want high"); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (trace[k] !== 2'(k / 2)) begin errors++; $display("FAIL and_drive[%0d] got %0d want %0d", k, trace[k], k / 2); end
        end
        checks++; if (drive_a !== 2'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL and_done_idle got drive=%0d busy=%b want 0 0", drive_a, busy_a); end
    endtask

    task automatic test_or_dut();
        run_a(1, 1'b0);
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc)) begin errors++; $display("FAIL or_done_cycle got %0d want %0d", done_at, e.cyc); end
        checks++; if (err_count_a !== e.err || fail_vec_a !== e.fv) begin errors++; $display("FAIL or_err got err=%0d fv=%0d want %0d %0d", err_count_a, fail_vec_a, e.err, e.fv); end
        checks++; if (pass_a !== e.pass || fail_valid_a !== e.fvalid) begin errors++; $display("FAIL or_pass got pass=%b fvalid=%b want %b %b", pass_a, fail_valid_a, e.pass, e.fvalid); end
    endtask

    task automatic test_stuck0();
        run_a(2, 1'b0);
        e = sb.pop_front();
        checks++; if (err_count_a !== e.err || fail_vec_a !== e.fv || pass_a !== e.pass) begin errors++; $display("FAIL stuck_result got err=%0d fv=%0d pass=%b want %0d %0d %b", err_count_a, fail_vec_a, pass_a, e.err, e.fv, e.pass); end
        checks++; if (obs_table_a !== e.obs) begin errors++; $display("FAIL stuck_obs got %b want %b", obs_table_a, e.obs); end
        @(negedge clk);
        checks++; if (done_a !== 1'b0 || err_count_a !== e.err || fail_valid_a !== 1'b1) begin errors++; $display("FAIL stuck_hold got done=%b err=%0d fvalid=%b want 0 %0d 1", done_a, err_count_a, fail_valid_a, e.err); end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        mode_a = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || drive_a !== 2'd1) begin errors++; $display("FAIL abort_pre got busy=%b drive=%0d want 1 1", busy_a, drive_a); end
        rst = 1'b1;
        #1;
        checks++; if (drive_a !== 2'd0 || busy_a !== 1'b0) begin errors++; $display("FAIL abort_now got drive=%0d busy=%b want 0 0", drive_a, busy_a); end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_a || busy_a) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_quiet got activity=1 want 0"); end
        run_a(0, 1'b0);
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc) || pass_a !== e.pass) begin errors++; $display("FAIL abort_rerun got done_at=%0d pass=%b want %0d %b", done_at, pass_a, e.cyc, e.pass); end
    endtask

    task automatic test_back_to_back();
        run_a(1, 1'b1);
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc) || err_count_a !== e.err || busy_lo) begin errors++; $display("FAIL held_first got done_at=%0d err=%0d busy_lo=%b want %0d %0d 0", done_at, err_count_a, busy_lo, e.cyc, e.err); end
        sb.push_back(expect_for(0, 1));
        mode_a = 0;
        @(negedge clk);
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_count_a !== 3'd2) begin errors++; $display("FAIL held_idle got busy=%b done=%b err=%0d want 0 0 2", busy_a, done_a, err_count_a); end
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || err_count_a !== 3'd0 || pass_a !== 1'b0) begin errors++; $display("FAIL b2b_clear got busy=%b err=%0d pass=%b want 1 0 0", busy_a, err_count_a, pass_a); end
        start_a = 1'b0;
        done_at = -1;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (done_a) begin
                done_at = k;
                break;
            end
        end
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc) || pass_a !== e.pass || err_count_a !== e.err) begin errors++; $display("FAIL b2b_second got done_at=%0d pass=%b err=%0d want %0d %b %0d", done_at, pass_a, err_count_a, e.cyc, e.pass, e.err); end
    endtask

    task automatic test_settle0();
        sb.push_back(expect_for(0, 0));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (done_b) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++; if (done_at !== int'(e.cyc)) begin errors++; $display("FAIL s0_done_cycle got %0d want %0d", done_at, e.cyc); end
        checks++; if (pass_b !== e.pass || err_count_b !== e.err || fail_valid_b !== e.fvalid || fail_vec_b !== e.fv) begin errors++; $display("FAIL s0_result got pass=%b err=%0d fvalid=%b fv=%0d want %b %0d %b %0d", pass_b, err_count_b, fail_valid_b, fail_vec_b, e.pass, e.err, e.fvalid, e.fv); end
        checks++; if (obs_table_b !== e.obs || drive_b !== 2'd0) begin errors++; $display("FAIL s0_obs got obs=%b drive=%0d want %b 0", obs_table_b, drive_b, e.obs); end
    endtask

    initial begin
        test_reset();
        test_and_sweep();
        test_or_dut();
        test_stuck0();
        test_reset_mid_run();
        test_back_to_back();
        test_settle0();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
